// File: rtl/gate_identifier.sv
// gate_identifier: exercises an unknown two-input gate with all four input
// combinations, waits SETTLE_CYCLES extra cycles per combination, samples the
// gate output into a truth table and reports which standard function it is.
module gate_identifier #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth,
  output logic [2:0] gate_code,
  output logic       valid
);

  // Last counter value of a combination; the sample is taken on this cycle.
  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StReport
  } state_e;

  state_e     state;
  logic [1:0] combo;
  logic [3:0] count;
  logic [3:0] shadow;

  logic [2:0] match_code;
  logic       match_valid;

  // Decode the captured table into a function code; unknown tables report 0/invalid.
  always_comb begin
    match_code  = 3'd0;
    match_valid = 1'b1;
    unique case (shadow)
      4'b1000: match_code = 3'd0;  // AND
      4'b1110: match_code = 3'd1;  // OR
      4'b0011: match_code = 3'd2;  // NOT a
      4'b0101: match_code = 3'd3;  // NOT b
      4'b0111: match_code = 3'd4;  // NAND
      4'b0001: match_code = 3'd5;  // NOR
      4'b0110: match_code = 3'd6;  // XOR
      4'b1001: match_code = 3'd7;  // XNOR
      default: begin
        match_code  = 3'd0;
        match_valid = 1'b0;
      end
    endcase
  end

  // Sequencer with registered outputs: stimulus changes only on combo boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      combo     <= 2'd0;
      count     <= 4'd0;
      shadow    <= 4'd0;
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      truth     <= 4'd0;
      gate_code <= 3'd0;
      valid     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            state <= StDrive;
            combo <= 2'd0;
            count <= 4'd0;
            a_out <= 1'b0;
            b_out <= 1'b0;
            busy  <= 1'b1;
          end
        end

        StDrive: begin
          if (count == SettleLast) begin
            shadow[combo] <= y_in;
            if (combo == 2'd3) begin
              // Stimulus returns to 00 for the report cycle.
              state <= StReport;
              a_out <= 1'b0;
              b_out <= 1'b0;
              done  <= 1'b1;
            end else begin
              combo          <= combo + 2'd1;
              count          <= 4'd0;
              {a_out, b_out} <= combo + 2'd1;
            end
          end else begin
            count <= count + 4'd1;
          end
        end

        StReport: begin
          state     <= StIdle;
          busy      <= 1'b0;
          truth     <= shadow;
          gate_code <= match_code;
          valid     <= match_valid;
        end

        default: begin
          state <= StIdle;
          busy  <= 1'b0;
          a_out <= 1'b0;
          b_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
